cmdout_reader: RTL

- Synthesizable, parametrised consumer of the per-accelerator command-out queues held in a 64-bit BRAM.
- Round-robins over NUM_ACCS subqueues and detects valid entries by the header valid byte.
- Streams each variable-length entry (header plus 1..MAX_PAYLOAD payload words) out on a valid/ready interface, then clears the header valid byte and advances the slot pointer with wrap-around.
- Sits between the cmdout BRAM and the host-side completion logic.

---
 rtl/cmdout_pkg.sv | 29 ++
 rtl/cmdout_rr_ptr.sv | 30 +++
 rtl/cmdout_reader.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/cmdout_pkg.sv
// Shared types and constants for the command-out queue reader.
// Header layout: [63:56] valid byte, [3:0] payload word count.
package cmdout_pkg;

  typedef enum logic [2:0] {
    ST_ISSUE_RD,
    ST_READ_HDR,
    ST_SEND_HDR,
    ST_READ_PAY,
    ST_SEND_PAY,
    ST_CLEAR,
    ST_ERROR
  } state_e;

  localparam int VALID_HI = 63;
  localparam int VALID_LO = 56;
  localparam int LEN_HI   = 3;
  localparam int LEN_LO   = 0;

  localparam logic [7:0] CLEAR_BE = 8'h80;

  // Subqueue length is a power of two, so the modulo is a mask.
  function automatic logic [31:0] slot_add(input logic [31:0] slot,
                                           input logic [31:0] k,
                                           input int unsigned  sub_len);
    return (slot + k) & (sub_len - 1);
  endfunction

endpackage

// File: rtl/cmdout_rr_ptr.sv
// Round-robin accelerator pointer: steps by one on advance, wrapping at NUM_ACCS.
module cmdout_rr_ptr #(
  parameter int NUM_ACCS = 16,
  parameter int ACC_BITS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                advance,
  output logic [ACC_BITS-1:0] ptr
);

  logic [ACC_BITS-1:0] ptr_q, ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (ptr_q == ACC_BITS'(NUM_ACCS - 1)) ? '0 : ptr_q + 1'b1;
    end
  end

  // NOTE: reset here is synchronous, so rst is sampled only on the clock edge
  // and stays out of the sensitivity list.
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr = ptr_q;

endmodule

// File: rtl/cmdout_reader.sv
// Drains per-accelerator command-out subqueues from a 64-bit BRAM onto a valid/ready stream.
// Optional statistics counters are enabled with `define CMDOUT_STATS_EN.
module cmdout_reader
  import cmdout_pkg::*;
#(
  parameter int         NUM_ACCS     = 16,
  parameter int         SUBQUEUE_LEN = 64,
  parameter int         MAX_PAYLOAD  = 15,
  parameter logic [7:0] VALID_CODE   = 8'h80,
  localparam int        ACC_BITS     = (NUM_ACCS > 1) ? $clog2(NUM_ACCS) : 1,
  localparam int        SLOT_BITS    = $clog2(SUBQUEUE_LEN)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                mem_en,
  output logic [7:0]          mem_wr,
  output logic [31:0]         mem_addr,
  output logic [63:0]         mem_din,
  input  logic [63:0]         mem_dout,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [63:0]         out_data,
  output logic                out_last,
  output logic [ACC_BITS-1:0] out_acc,
  output logic                err
`ifdef CMDOUT_STATS_EN
  ,
  output logic [31:0]         entries_done,
  output logic [31:0]         stall_cycles
`endif
);

  state_e                state_q, state_d;
  logic [SLOT_BITS-1:0]  slot_idx_q [NUM_ACCS];
  logic [SLOT_BITS-1:0]  slot_idx_d [NUM_ACCS];
  logic [3:0]            len_q, len_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [63:0]           data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  last_q, last_d;
  logic [ACC_BITS-1:0]   oacc_q, oacc_d;
  logic                  err_q, err_d;

  logic [ACC_BITS-1:0]   acc_ptr;
  logic                  advance;
  logic [SLOT_BITS-1:0]  hdr_slot;
  logic [SLOT_BITS-1:0]  addr_slot;
  logic [31:0]           addr_k;
  logic [31:0]           addr_sum;
  logic [31:0]           next_sum;
  logic [3:0]            hdr_len;
  logic                  hdr_valid;
  logic                  len_ok;

  cmdout_rr_ptr #(
    .NUM_ACCS (NUM_ACCS),
    .ACC_BITS (ACC_BITS)
  ) u_rr_ptr (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .ptr     (acc_ptr)
  );

  assign hdr_slot  = slot_idx_q[acc_ptr];
  assign hdr_len   = mem_dout[LEN_HI:LEN_LO];
  assign hdr_valid = (mem_dout[VALID_HI:VALID_LO] == VALID_CODE);
  assign len_ok    = (hdr_len != 4'd0) && (int'(hdr_len) <= MAX_PAYLOAD);

  // The address always points at the word needed next, so a read issued in a
  // SEND_* state lands in the following READ_PAY cycle.
  always_comb begin
    addr_k = 32'd0;
    unique case (state_q)
      ST_SEND_HDR: addr_k = 32'd1;
      ST_READ_PAY: addr_k = 32'(cnt_q);
      ST_SEND_PAY: addr_k = 32'(cnt_q) + 32'd1;
      default:     addr_k = 32'd0;
    endcase
  end

  assign addr_sum  = slot_add(32'(hdr_slot), addr_k, SUBQUEUE_LEN);
  assign addr_slot = addr_sum[SLOT_BITS-1:0];
  assign next_sum  = slot_add(32'(hdr_slot), 32'(len_q) + 32'd1, SUBQUEUE_LEN);

  assign mem_en   = 1'b1;
  assign mem_din  = 64'd0;
  assign mem_wr   = (state_q == ST_CLEAR) ? CLEAR_BE : 8'h00;
  assign mem_addr = 32'({acc_ptr, addr_slot, 3'b000});

  // NOTE: every signal written here gets its default first, so no path through
  // the case statement can infer a latch.
  always_comb begin
    state_d    = state_q;
    slot_idx_d = slot_idx_q;
    len_d      = len_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    valid_d    = valid_q;
    last_d     = last_q;
    oacc_d     = oacc_q;
    err_d      = err_q;
    advance    = 1'b0;

    unique case (state_q)
      ST_ISSUE_RD: state_d = ST_READ_HDR;
      ST_READ_HDR: begin
        if (!hdr_valid) begin
          advance = 1'b1;
          state_d = ST_ISSUE_RD;
        end else if (len_ok) begin
          len_d   = hdr_len;
          data_d  = mem_dout;
          valid_d = 1'b1;
          last_d  = 1'b0;
          oacc_d  = acc_ptr;
          state_d = ST_SEND_HDR;
        end else begin
          err_d   = 1'b1;
          state_d = ST_ERROR;
        end
      end
      ST_SEND_HDR: begin
        if (out_ready) begin
          valid_d = 1'b0;
          cnt_d   = 4'd1;
          state_d = ST_READ_PAY;
        end
      end
      ST_READ_PAY: begin
        data_d  = mem_dout;
        valid_d = 1'b1;
        last_d  = (cnt_q == len_q);
        state_d = ST_SEND_PAY;
      end
      ST_SEND_PAY: begin
        if (out_ready) begin
          valid_d = 1'b0;
          if (last_q) begin
            state_d = ST_CLEAR;
          end else begin
            cnt_d   = cnt_q + 4'd1;
            state_d = ST_READ_PAY;
          end
        end
      end
      ST_CLEAR: begin
        slot_idx_d[acc_ptr] = next_sum[SLOT_BITS-1:0];
        advance             = 1'b1;
        state_d             = ST_ISSUE_RD;
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_ISSUE_RD;
    endcase
  end

  // NOTE: slot_idx is a small register array rather than a RAM, so it is
  // reset explicitly; pointers must restart at slot 0 after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_ISSUE_RD;
      for (int i = 0; i < NUM_ACCS; i++) slot_idx_q[i] <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      oacc_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      slot_idx_q <= slot_idx_d;
      len_q      <= len_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      last_q     <= last_d;
      oacc_q     <= oacc_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign out_acc   = oacc_q;
  assign err       = err_q;

`ifdef CMDOUT_STATS_EN
  logic [31:0] entries_q, entries_d;
  logic [31:0] stall_q, stall_d;

  always_comb begin
    entries_d = entries_q;
    stall_d   = stall_q;
    if (state_q == ST_CLEAR) entries_d = entries_q + 32'd1;
    if (valid_q && !out_ready && (stall_q != 32'hFFFF_FFFF)) stall_d = stall_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      entries_q <= '0;
      stall_q   <= '0;
    end else begin
      entries_q <= entries_d;
      stall_q   <= stall_d;
    end
  end

  assign entries_done = entries_q;
  assign stall_cycles = stall_q;
`endif

endmodule
